touch_ctrl: RTL and testbench
=============================

Name: touch_ctrl

Overview:
Debounce and event controller for the raw touch/key input that the top level currently passes straight through. It synchronises the asynchronous pad signal, rejects bounce, and produces a clean level. It also queues press, release and long-press events into a one-entry valid/ready buffer for downstream logic such as menu and LED control. It sits between the touch pad pin and all consumers of touch state.

Parameters:
DB_CYC, 50000, consecutive stable clk cycles required to accept a level change (min 2)
LONG_CYC, 10000000, cycles in PRESSED before a long-press event (min 1)
REPEAT_CYC, 2500000, auto-repeat interval in LONG_HELD (used only with TOUCH_REPEAT_EN)
CNT_W, 24, width of the debounce and hold counters; must hold the largest of the three values above

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
touch_in  input  1  raw asynchronous touch pad level, 1 = touched
touch_out  output  1  debounced level
evt_valid  output  1  event buffer holds an event
evt_code  output  2  event type: 01 press, 10 release, 11 long/repeat; 00 when evt_valid=0
evt_ready  input  1  consumer accepts the event on a cycle where evt_valid&evt_ready
evt_ovf  output  1  sticky flag: an event was dropped

Behaviour:
- Reset (synchronous, active-high): sync flops=0, state=IDLE, db_cnt=0, hold_cnt=0, touch_out=0, evt_valid=0, evt_code=00, evt_ovf=0. A pending event is discarded. rst dominates every other input.
- Synchroniser: 2 flops; FSM uses raw_s = 2nd flop output.
- IDLE: raw_s=1 -> DB_ON, db_cnt=0.
- DB_ON: raw_s=0 -> IDLE, no event (glitch rejected). Otherwise db_cnt++. When db_cnt==DB_CYC-1 -> PRESSED, touch_out=1, hold_cnt=0, emit PRESS.
- PRESSED: raw_s=0 -> DB_OFF, db_cnt=0. Otherwise hold_cnt++. When hold_cnt==LONG_CYC-1 -> LONG_HELD, emit LONG, hold_cnt=0.
- LONG_HELD: raw_s=0 -> DB_OFF, db_cnt=0.
- DB_OFF: raw_s=1 -> return to the state it came from (PRESSED or LONG_HELD); hold_cnt keeps its value, no event. Otherwise db_cnt++. When db_cnt==DB_CYC-1 -> IDLE, touch_out=0, emit RELEASE.
- Latency: if touch_in is stable 1 before clk edge k, touch_out=1 and evt_valid=1 with code 01 after edge k+DB_CYC+2. Release behaves symmetrically.
- Event buffer (1 entry), updated on the same edge as the emitting transition:
  - If buffer empty, or being accepted this cycle (evt_valid&evt_ready): load the new code, evt_valid=1.
  - If full and evt_ready=0: drop the new event, keep the old one, set evt_ovf=1 (cleared only by rst).
  - On accept with no new event: evt_valid=0 and evt_code=00 next cycle.
- touch_out is independent of buffer state; a dropped event never stalls the FSM.

Optional Feature:
Macro TOUCH_REPEAT_EN.
- Defined: in LONG_HELD, hold_cnt++; when hold_cnt==REPEAT_CYC-1, emit code 11 again and reset hold_cnt=0. Repeats continue until release. Buffer and overflow rules as above.
- Undefined: LONG_HELD only waits for release; exactly one 11 per press; REPEAT_CYC unused; no repeat logic synthesised.

Test Plan:
All tests use DB_CYC=4, LONG_CYC=20, REPEAT_CYC=8, evt_ready=1 unless stated.
1. Glitch: touch_in=1 for 3 cycles then 0 -> touch_out stays 0, evt_valid never asserts, evt_ovf=0.
2. Clean press: touch_in rises before edge k, held 12 cycles -> touch_out=1 and evt_code=01 after edge k+6, evt_valid high 1 cycle. After the fall, touch_out=0 and evt_code=10 6 edges later.
3. Long press: hold 40 cycles -> codes 01, then 11 exactly 20 cycles after 01, then 10 after release; 11 occurs once with macro undefined.
4. Backpressure: evt_ready=0 during a short press and release -> evt_valid=1 with code 01 held, release dropped, evt_ovf=1. Then evt_ready=1 for 1 cycle -> evt_valid=0 next cycle, evt_ovf stays 1.
5. Reset mid-operation: assert rst in DB_OFF with a pending event -> all outputs 0 after the next edge. With touch_in still 1 after rst deasserts, a fresh 01 appears DB_CYC+2 edges later.
6. TOUCH_REPEAT_EN defined, hold 50 cycles -> 11 at +20, +28, +36, +44 cycles after the 01 event, then 10 on release.

Source files
------------

// File: rtl/touch_ctrl.sv
// Touch pad conditioner: 2-flop synchroniser, debounce FSM and a one-entry press/release/long event buffer.
// Define TOUCH_REPEAT_EN to make LONG_HELD re-emit the long code every REPEAT_CYC cycles until release.
module touch_ctrl #(
    parameter int DB_CYC     = 50000,
    parameter int LONG_CYC   = 10000000,
    parameter int REPEAT_CYC = 2500000,
    parameter int CNT_W      = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       touch_in,
    output logic       touch_out,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       evt_ovf
);

    typedef enum logic [2:0] {IDLE, DB_ON, PRESSED, LONG_HELD, DB_OFF} state_t;

    localparam logic [1:0] EV_PRESS   = 2'b01;
    localparam logic [1:0] EV_RELEASE = 2'b10;
    localparam logic [1:0] EV_LONG    = 2'b11;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
`ifdef TOUCH_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
`endif

    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    if (DB_CYC < 2 || LONG_CYC < 1 || REPEAT_CYC < 1 ||
        longint'(DB_CYC) > CNT_MAX || longint'(LONG_CYC) > CNT_MAX ||
        longint'(REPEAT_CYC) > CNT_MAX) begin : g_bad_params
        $error("touch_ctrl: parameter out of range");
    end

    logic             sync1_q, sync2_q;
    logic             raw_s;
    state_t           state_q;
    logic [CNT_W-1:0] db_cnt_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic             from_long_q;
    logic             touch_out_q;
    logic             evt_valid_q;
    logic [1:0]       evt_code_q;
    logic             evt_ovf_q;
    logic             emit_d;
    logic [1:0]       emit_code_d;

    assign raw_s = sync2_q;

    // Event produced by the transition the FSM takes on this edge.
    always_comb begin
        emit_d      = 1'b0;
        emit_code_d = 2'b00;
        case (state_q)
            DB_ON: if (raw_s && db_cnt_q == DB_LAST) begin
                emit_d      = 1'b1;
                emit_code_d = EV_PRESS;
            end
            PRESSED: if (raw_s && hold_cnt_q == LONG_LAST) begin
                emit_d      = 1'b1;
                emit_code_d = EV_LONG;
            end
`ifdef TOUCH_REPEAT_EN
            LONG_HELD: if (raw_s && hold_cnt_q == REP_LAST) begin
                emit_d      = 1'b1;
                emit_code_d = EV_LONG;
            end
`endif
            DB_OFF: if (!raw_s && db_cnt_q == DB_LAST) begin
                emit_d      = 1'b1;
                emit_code_d = EV_RELEASE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            from_long_q <= 1'b0;
            touch_out_q <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= 2'b00;
            evt_ovf_q   <= 1'b0;
        end else begin
            sync1_q <= touch_in;
            sync2_q <= sync1_q;

            case (state_q)
                IDLE: if (raw_s) begin
                    state_q  <= DB_ON;
                    db_cnt_q <= '0;
                end
                DB_ON: begin
                    if (!raw_s) begin
                        state_q <= IDLE;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q     <= PRESSED;
                        touch_out_q <= 1'b1;
                        hold_cnt_q  <= '0;
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!raw_s) begin
                        state_q     <= DB_OFF;
                        db_cnt_q    <= '0;
                        from_long_q <= 1'b0;
                    end else if (hold_cnt_q == LONG_LAST) begin
                        state_q    <= LONG_HELD;
                        hold_cnt_q <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                LONG_HELD: begin
                    if (!raw_s) begin
                        state_q     <= DB_OFF;
                        db_cnt_q    <= '0;
                        from_long_q <= 1'b1;
                    end
`ifdef TOUCH_REPEAT_EN
                    else if (hold_cnt_q == REP_LAST) begin
                        hold_cnt_q <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
`endif
                end
                DB_OFF: begin
                    // A bounce back to 1 resumes the held state with its hold count intact.
                    if (raw_s) begin
                        state_q <= from_long_q ? LONG_HELD : PRESSED;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q     <= IDLE;
                        touch_out_q <= 1'b0;
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (emit_d) begin
                if (!evt_valid_q || evt_ready) begin
                    evt_valid_q <= 1'b1;
                    evt_code_q  <= emit_code_d;
                end else begin
                    evt_ovf_q <= 1'b1;
                end
            end else if (evt_valid_q && evt_ready) begin
                evt_valid_q <= 1'b0;
                evt_code_q  <= 2'b00;
            end
        end
    end

    assign touch_out = touch_out_q;
    assign evt_valid = evt_valid_q;
    assign evt_code  = evt_code_q;
    assign evt_ovf   = evt_ovf_q;

endmodule

// File: tb/tb_touch_ctrl.sv
// Bench for touch_ctrl: directed vector table, hand sequences for long press and reset,
// and random stimulus checked every cycle against a run-length reference model.
module tb_touch_ctrl;

    localparam int DB   = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       touch_in;
    logic       evt_ready;
    logic       touch_out;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_ovf;

    int errors = 0;
    int checks = 0;

    touch_ctrl #(
        .DB_CYC    (DB),
        .LONG_CYC  (LONG),
        .REPEAT_CYC(REP),
        .CNT_W     (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .touch_in (touch_in),
        .touch_out(touch_out),
        .evt_valid(evt_valid),
        .evt_code (evt_code),
        .evt_ready(evt_ready),
        .evt_ovf  (evt_ovf)
    );

    always #5 clk = ~clk;

    // Reference model: pad delayed two edges, then a level that flips once the
    // delayed input has disagreed with it for DB+1 consecutive samples.
    bit         m_s1 = 0, m_s2 = 0, m_lvl = 0, m_long = 0;
    int         m_run = 0, m_held = 0;
    bit         m_vld = 0, m_ovf = 0;
    logic [1:0] m_code = 2'b00;

    task automatic model_edge(input bit tin, input bit rdy, input bit r);
        bit         raw;
        bit         emit;
        logic [1:0] c;
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_long = 0;
            m_run = 0; m_held = 0; m_vld = 0; m_ovf = 0; m_code = 2'b00;
            return;
        end
        raw  = m_s2;
        m_s2 = m_s1;
        m_s1 = tin;
        emit = 0;
        c    = 2'b00;
        if (raw != m_lvl) begin
            m_run++;
            if (m_run == DB + 1) begin
                m_lvl  = raw;
                m_run  = 0;
                emit   = 1;
                c      = raw ? 2'b01 : 2'b10;
                m_held = 0;
                m_long = 0;
            end
        end else if (m_run > 0) begin
            m_run = 0;
        end else if (m_lvl) begin
            m_held++;
            if (!m_long && m_held == LONG) begin
                emit = 1; c = 2'b11; m_long = 1; m_held = 0;
            end
`ifdef TOUCH_REPEAT_EN
            else if (m_long && m_held == REP) begin
                emit = 1; c = 2'b11; m_held = 0;
            end
`endif
        end
        if (emit) begin
            if (!m_vld || rdy) begin
                m_vld  = 1;
                m_code = c;
            end else begin
                m_ovf = 1;
            end
        end else if (m_vld && rdy) begin
            m_vld  = 0;
            m_code = 2'b00;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(touch_in, evt_ready, rst);
        #1;
        chk("model", {touch_out, evt_valid, evt_code, evt_ovf}, {m_lvl, m_vld, m_code, m_ovf});
    endtask

    typedef struct {
        bit         tin;
        bit         rdy;
        int         n;
        bit         out;
        bit         vld;
        logic [1:0] code;
        bit         ovf;
    } vec_t;

    vec_t       vecs[$];
    int         got_at[$];
    logic [1:0] got_code[$];
    int         exp_at[$];
    logic [1:0] exp_code[$];
    int         hold_len;
    int         seg_len;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Glitch of 3 cycles, clean 12-cycle press, then press/release under backpressure.
        vecs.push_back('{1'b0, 1'b1, 3, 1'b0, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3, 1'b0, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 6, 1'b0, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 7, 1'b1, 1'b1, 2'b01, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1, 1'b1, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 4, 1'b1, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 6, 1'b1, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1, 1'b0, 1'b1, 2'b10, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1, 1'b0, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 7, 1'b1, 1'b1, 2'b01, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 6, 1'b1, 1'b1, 2'b01, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1, 1'b0, 1'b1, 2'b01, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1, 1'b0, 1'b0, 2'b00, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 2, 1'b0, 1'b0, 2'b00, 1'b1});

        rst = 1'b1; touch_in = 1'b0; evt_ready = 1'b1;
        repeat (3) step();
        chk("reset_state", {touch_out, evt_valid, evt_code, evt_ovf}, 5'b0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            touch_in  = vecs[i].tin;
            evt_ready = vecs[i].rdy;
            repeat (vecs[i].n) step();
            chk($sformatf("vec%0d", i), {touch_out, evt_valid, evt_code, evt_ovf},
                {vecs[i].out, vecs[i].vld, vecs[i].code, vecs[i].ovf});
        end

        // Reset while debouncing a release with an event still pending.
        evt_ready = 1'b0; touch_in = 1'b1;
        repeat (7) step();
        chk("rst_pre_press", {touch_out, evt_valid, evt_code}, {1'b1, 1'b1, 2'b01});
        touch_in = 1'b0;
        repeat (3) step();
        touch_in = 1'b1; rst = 1'b1;
        step();
        chk("rst_clear", {touch_out, evt_valid, evt_code, evt_ovf}, 5'b0);
        rst = 1'b0;
        repeat (6) step();
        chk("rst_no_early", {touch_out, evt_valid}, 2'b00);
        step();
        chk("rst_repress", {touch_out, evt_valid, evt_code, evt_ovf}, {1'b1, 1'b1, 2'b01, 1'b0});
        evt_ready = 1'b1; touch_in = 1'b0;
        repeat (12) step();

        // Long press: record the edge index of every event.
`ifdef TOUCH_REPEAT_EN
        hold_len = 50;
        exp_at   = '{6, 26, 34, 42, 50, 56};
        exp_code = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10};
`else
        hold_len = 40;
        exp_at   = '{6, 26, 46};
        exp_code = '{2'b01, 2'b11, 2'b10};
`endif
        touch_in = 1'b1;
        for (int e = 0; e < hold_len + 12; e++) begin
            if (e == hold_len) touch_in = 1'b0;
            step();
            if (evt_valid) begin
                got_at.push_back(e);
                got_code.push_back(evt_code);
            end
        end
        chk("long_evt_count", got_at.size(), exp_at.size());
        foreach (exp_at[i]) begin
            if (i < got_at.size()) begin
                chk($sformatf("long_evt%0d_at", i), got_at[i], exp_at[i]);
                chk($sformatf("long_evt%0d_code", i), got_code[i], exp_code[i]);
            end
        end

        // Random segments: short bursts make glitches, long ones reach long-press.
        for (int s = 0; s < 160; s++) begin
            if ($urandom_range(0, 4) == 0) seg_len = $urandom_range(25, 60);
            else seg_len = $urandom_range(1, 12);
            touch_in = 1'($urandom_range(0, 1));
            for (int c = 0; c < seg_len; c++) begin
                evt_ready = ($urandom_range(0, 3) != 0);
                rst       = ($urandom_range(0, 399) == 0);
                step();
            end
        end
        rst = 1'b0;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
